instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_if.sv | 31 +++
 rtl/instruction_fetch.sv | 54 +++++
 tb/tb_instruction_fetch.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: PC, memory and decoder signals of the instruction fetch unit
//   pc side:      pc_in in; pc_inc, pc_load, pc_load_addr out
//   memory side:  mem_addr, mem_rd out; mem_rdata, mem_ready in
//   control:      fetch_en, redirect, redirect_addr in
//   decoder side: instr_valid, opcode, operand, instr_addr out; instr_ready in
interface instruction_fetch_if;
  logic fetch_en;
  logic [15:0] pc_in;
  logic pc_inc;
  logic pc_load;
  logic [15:0] pc_load_addr;
  logic [15:0] mem_addr;
  logic mem_rd;
  logic [7:0] mem_rdata;
  logic mem_ready;
  logic redirect;
  logic [15:0] redirect_addr;
  logic instr_valid;
  logic instr_ready;
  logic [7:0] opcode;
  logic [15:0] operand;
  logic [15:0] instr_addr;
  modport master (
    input fetch_en, pc_in, mem_rdata, mem_ready, redirect, redirect_addr, instr_ready,
    output pc_inc, pc_load, pc_load_addr, mem_addr, mem_rd, instr_valid, opcode, operand, instr_addr
  );
  modport slave (
    output fetch_en, pc_in, mem_rdata, mem_ready, redirect, redirect_addr, instr_ready,
    input pc_inc, pc_load, pc_load_addr, mem_addr, mem_rd, instr_valid, opcode, operand, instr_addr
  );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: assembles 1-3 byte instructions from a byte-wide memory
//   clk, reset: clock and synchronous active-high reset
//   bus: instruction_fetch_if.master carrying PC, memory, redirect and decoder signals
module instruction_fetch (
  input logic clk,
  input logic reset,
  instruction_fetch_if.master bus
);
  typedef enum logic [1:0] {FETCH_OP, FETCH_B1, FETCH_B2, HOLD} state_t;
  state_t state, state_nx;
  logic [7:0] opcode_q;
  logic [15:0] operand_q;
  logic [15:0] addr_q;
  logic rd;
  logic acc;
  always_ff @(posedge clk)
    if (reset) state <= FETCH_OP;
    else state <= state_nx;
  // Length is taken from the live byte in FETCH_OP and from the captured opcode afterwards
  always_comb begin
    state_nx = state;
    if (bus.redirect) state_nx = FETCH_OP;
    else if (acc)
      state_nx = state == FETCH_OP ? (bus.mem_rdata[7:6] == 2'b00 ? HOLD : FETCH_B1) :
                 state == FETCH_B1 ? (opcode_q[7] ? FETCH_B2 : HOLD) : HOLD;
    else if (state == HOLD && bus.instr_ready && bus.fetch_en) state_nx = FETCH_OP;
  end
  always_comb begin
    rd = state != HOLD && bus.fetch_en && !reset && !bus.redirect;
    acc = rd && bus.mem_ready;
    bus.mem_rd = rd;
    bus.pc_inc = acc;
    bus.pc_load = bus.redirect && !reset;
    bus.pc_load_addr = bus.redirect_addr;
    bus.mem_addr = bus.pc_in;
    bus.instr_valid = state == HOLD && !reset;
    bus.opcode = opcode_q;
    bus.operand = operand_q;
    bus.instr_addr = addr_q;
  end
  always_ff @(posedge clk)
    if (reset) begin
      opcode_q <= 8'h00;
      operand_q <= 16'h0000;
      addr_q <= 16'h0000;
    end else if (acc) begin
      if (state == FETCH_OP) begin
        opcode_q <= bus.mem_rdata;
        operand_q <= 16'h0000;
        addr_q <= bus.pc_in;
      end else if (state == FETCH_B1) operand_q[7:0] <= bus.mem_rdata;
      else operand_q[15:8] <= bus.mem_rdata;
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed tests of instruction_fetch against a PC and memory model
module tb_instruction_fetch;
  logic clk = 1'b0;
  logic reset;
  logic [15:0] pc = 16'h0000;
  logic [7:0] mem [0:65535];
  int inc_cnt = 0;
  int errors = 0;
  int checks = 0;
  int c0;
  instruction_fetch_if bus ();
  instruction_fetch u_dut (.clk(clk), .reset(reset), .bus(bus.master));
  always #5 clk = ~clk;
  assign bus.pc_in = pc;
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (reset) pc <= 16'h0000;
    else if (bus.pc_load) pc <= bus.pc_load_addr;
    else if (bus.pc_inc) pc <= pc + 16'h0001;
    if (bus.pc_inc) inc_cnt <= inc_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [15:0] a);
    bus.redirect = 1'b1;
    bus.redirect_addr = a;
    step();
    bus.redirect = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.fetch_en = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_addr = 16'h1234;
    bus.instr_ready = 1'b1;
    bus.mem_ready = 1'b1;
    step();
    step();
    checks++;
    if ({bus.mem_rd, bus.pc_inc, bus.pc_load, bus.instr_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 0000", {bus.mem_rd, bus.pc_inc, bus.pc_load, bus.instr_valid});
    end
    checks++;
    if ({bus.opcode, bus.operand, bus.instr_addr} !== 40'h0) begin
      errors++;
      $display("FAIL reset_regs: got %h/%h/%h want 00/0000/0000", bus.opcode, bus.operand, bus.instr_addr);
    end
    bus.redirect = 1'b0;
    #1;
    checks++;
    if (bus.pc_load !== 1'b0 || bus.pc_load_addr !== 16'h1234) begin
      errors++;
      $display("FAIL pc_load_idle: got %b/%h want 0/1234", bus.pc_load, bus.pc_load_addr);
    end
  endtask

  task automatic test_one_byte();
    bus.instr_ready = 1'b0;
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.mem_rd !== 1'b1 || bus.pc_inc !== 1'b1 || bus.mem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL one_byte_accept: got rd=%b inc=%b addr=%h want 1/1/0000", bus.mem_rd, bus.pc_inc, bus.mem_addr);
    end
    step();
    checks++;
    if ({bus.instr_valid, bus.mem_rd, bus.pc_inc} !== 3'b100 || {bus.opcode, bus.operand, bus.instr_addr} !== 40'h05_0000_0000) begin
      errors++;
      $display("FAIL one_byte_hold: got v=%b rd=%b inc=%b %h/%h/%h want 1/0/0 05/0000/0000",
               bus.instr_valid, bus.mem_rd, bus.pc_inc, bus.opcode, bus.operand, bus.instr_addr);
    end
    bus.instr_ready = 1'b1;
    bus.mem_ready = 1'b0;
    step();
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_three_byte();
    bus.redirect = 1'b1;
    bus.redirect_addr = 16'h0010;
    #1;
    checks++;
    if (bus.pc_load !== 1'b1 || bus.pc_load_addr !== 16'h0010 || bus.pc_inc !== 1'b0 || bus.mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL redirect_strobe: got load=%b addr=%h inc=%b rd=%b want 1/0010/0/0", bus.pc_load, bus.pc_load_addr, bus.pc_inc, bus.mem_rd);
    end
    step();
    bus.redirect = 1'b0;
    c0 = inc_cnt;
    bus.mem_ready = 1'b1;
    bus.instr_ready = 1'b1;
    step();
    step();
    step();
    checks++;
    if (bus.instr_valid !== 1'b1 || {bus.opcode, bus.operand, bus.instr_addr} !== 40'h8A_1234_0010) begin
      errors++;
      $display("FAIL three_byte: got v=%b %h/%h/%h want 1 8A/1234/0010", bus.instr_valid, bus.opcode, bus.operand, bus.instr_addr);
    end
    checks++;
    if (inc_cnt - c0 != 3 || pc !== 16'h0013) begin
      errors++;
      $display("FAIL three_byte_pc: got incs=%0d pc=%h want 3/0013", inc_cnt - c0, pc);
    end
    step();
    bus.mem_ready = 1'b0;
    bus.instr_ready = 1'b0;
    #1;
    checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0013 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL next_fetch: got rd=%b addr=%h v=%b want 1/0013/0", bus.mem_rd, bus.mem_addr, bus.instr_valid);
    end
  endtask

  task automatic test_wait_states();
    redirect_to(16'h0020);
    for (int b = 0; b < 2; b++) begin
      for (int w = 0; w < 2; w++) begin
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.mem_rd !== 1'b1 || bus.pc_inc !== 1'b0) begin
          errors++;
          $display("FAIL wait_state b%0d w%0d: got rd=%b inc=%b want 1/0", b, w, bus.mem_rd, bus.pc_inc);
        end
        step();
      end
      bus.mem_ready = 1'b1;
      #1;
      checks++;
      if (bus.pc_inc !== 1'b1 || bus.mem_addr !== 16'h0020 + 16'(b)) begin
        errors++;
        $display("FAIL wait_accept b%0d: got inc=%b addr=%h want 1/%h", b, bus.pc_inc, bus.mem_addr, 16'h0020 + 16'(b));
      end
      step();
    end
    checks++;
    if (bus.instr_valid !== 1'b1 || {bus.opcode, bus.operand, bus.instr_addr} !== 40'h4C_007F_0020) begin
      errors++;
      $display("FAIL two_byte: got v=%b %h/%h/%h want 1 4C/007F/0020", bus.instr_valid, bus.opcode, bus.operand, bus.instr_addr);
    end
  endtask

  task automatic test_hold();
    bus.instr_ready = 1'b0;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({bus.instr_valid, bus.mem_rd, bus.pc_inc} !== 3'b100 || {bus.opcode, bus.operand, bus.instr_addr} !== 40'h4C_007F_0020) begin
        errors++;
        $display("FAIL hold c%0d: got v=%b rd=%b inc=%b %h/%h/%h", i, bus.instr_valid, bus.mem_rd, bus.pc_inc, bus.opcode, bus.operand, bus.instr_addr);
      end
      step();
    end
    bus.instr_ready = 1'b1;
    bus.mem_ready = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_addr = 16'h0030;
    #1;
    checks++;
    if (bus.pc_load !== 1'b1 || bus.instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_redirect: got load=%b v=%b want 1/1", bus.pc_load, bus.instr_valid);
    end
    step();
    bus.redirect = 1'b0;
    bus.instr_ready = 1'b0;
    #1;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0030) begin
      errors++;
      $display("FAIL after_hold_redirect: got v=%b rd=%b addr=%h want 0/1/0030", bus.instr_valid, bus.mem_rd, bus.mem_addr);
    end
  endtask

  task automatic test_redirect();
    bus.mem_ready = 1'b1;
    step();
    bus.redirect = 1'b1;
    bus.redirect_addr = 16'h00F0;
    #1;
    checks++;
    if ({bus.pc_load, bus.pc_inc, bus.mem_rd, bus.instr_valid} !== 4'b1000 || bus.pc_load_addr !== 16'h00F0) begin
      errors++;
      $display("FAIL mid_redirect: got ld/inc/rd/v=%b addr=%h want 1000/00F0",
               {bus.pc_load, bus.pc_inc, bus.mem_rd, bus.instr_valid}, bus.pc_load_addr);
    end
    step();
    bus.redirect = 1'b0;
    #1;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.mem_addr !== 16'h00F0 || bus.pc_inc !== 1'b1) begin
      errors++;
      $display("FAIL redirect_fetch: got v=%b addr=%h inc=%b want 0/00F0/1", bus.instr_valid, bus.mem_addr, bus.pc_inc);
    end
    step();
    checks++;
    if (bus.instr_valid !== 1'b1 || {bus.opcode, bus.operand, bus.instr_addr} !== 40'h05_0000_00F0) begin
      errors++;
      $display("FAIL redirect_instr: got v=%b %h/%h/%h want 1 05/0000/00F0", bus.instr_valid, bus.opcode, bus.operand, bus.instr_addr);
    end
    bus.instr_ready = 1'b1;
    bus.mem_ready = 1'b0;
    step();
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_freeze_reset();
    redirect_to(16'h0040);
    bus.mem_ready = 1'b1;
    step();
    bus.fetch_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({bus.mem_rd, bus.pc_inc, bus.instr_valid} !== 3'b000 || bus.mem_addr !== 16'h0041) begin
        errors++;
        $display("FAIL freeze c%0d: got rd/inc/v=%b addr=%h want 000/0041", i, {bus.mem_rd, bus.pc_inc, bus.instr_valid}, bus.mem_addr);
      end
      step();
    end
    bus.fetch_en = 1'b1;
    #1;
    checks++;
    if (bus.pc_inc !== 1'b1 || bus.mem_addr !== 16'h0041) begin
      errors++;
      $display("FAIL unfreeze: got inc=%b addr=%h want 1/0041", bus.pc_inc, bus.mem_addr);
    end
    step();
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.mem_rd, bus.pc_inc, bus.pc_load, bus.instr_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_b2: got %b want 0000", {bus.mem_rd, bus.pc_inc, bus.pc_load, bus.instr_valid});
    end
    step();
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.opcode, bus.operand, bus.instr_addr} !== 40'h0 || bus.instr_valid !== 1'b0 || bus.mem_rd !== 1'b1) begin
      errors++;
      $display("FAIL reset_discard: got %h/%h/%h v=%b rd=%b want 00/0000/0000 0 1",
               bus.opcode, bus.operand, bus.instr_addr, bus.instr_valid, bus.mem_rd);
    end
    step();
    checks++;
    if (bus.instr_valid !== 1'b1 || {bus.opcode, bus.operand, bus.instr_addr} !== 40'h05_0000_0000) begin
      errors++;
      $display("FAIL post_reset_fetch: got v=%b %h/%h/%h want 1 05/0000/0000", bus.instr_valid, bus.opcode, bus.operand, bus.instr_addr);
    end
    bus.instr_ready = 1'b1;
    bus.mem_ready = 1'b0;
    step();
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_wrap();
    redirect_to(16'hFFFF);
    bus.mem_ready = 1'b1;
    step();
    step();
    checks++;
    if (bus.instr_valid !== 1'b1 || {bus.opcode, bus.operand, bus.instr_addr} !== 40'h41_0005_FFFF || pc !== 16'h0001) begin
      errors++;
      $display("FAIL wrap: got v=%b %h/%h/%h pc=%h want 1 41/0005/FFFF 0001",
               bus.instr_valid, bus.opcode, bus.operand, bus.instr_addr, pc);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h05;
    mem[16'h0010] = 8'h8A;
    mem[16'h0011] = 8'h34;
    mem[16'h0012] = 8'h12;
    mem[16'h0020] = 8'h4C;
    mem[16'h0021] = 8'h7F;
    mem[16'h0030] = 8'hC1;
    mem[16'h0031] = 8'hAA;
    mem[16'h00F0] = 8'h05;
    mem[16'h0040] = 8'h9B;
    mem[16'h0041] = 8'h11;
    mem[16'h0042] = 8'h22;
    mem[16'hFFFF] = 8'h41;
    test_reset();
    test_one_byte();
    test_three_byte();
    test_wait_states();
    test_hold();
    test_redirect();
    test_freeze_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
